// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_pkg
// Brief    : Opcodes, sequencer state encoding and default latencies for md_unit
// Revision : 1.0 - initial release
// ============================================================================
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // Ops that occupy the unit for a counted latency.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
// Module   : md_arith
// Brief    : Combinational signed/unsigned multiply and divide producing HI/LO
// Revision : 1.0 - initial release
// ============================================================================
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_ONES = {WIDTH{1'b1}};

  logic signed [2*WIDTH-1:0] w_sa, w_sb, w_sprod;
  logic        [2*WIDTH-1:0] w_uprod;
  logic        [WIDTH-1:0]   w_sdivisor, w_udivisor, w_uq, w_ur;
  logic signed [WIDTH-1:0]   w_sq, w_sr;
  logic                      w_b_zero, w_ovf;

  assign w_sa    = {{WIDTH{a[WIDTH-1]}}, a};
  assign w_sb    = {{WIDTH{b[WIDTH-1]}}, b};
  assign w_sprod = w_sa * w_sb;
  assign w_uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign w_b_zero = (b == '0);
  assign w_ovf    = (a == C_MIN) && (b == C_ONES);

  // Dividing by one in the zero and overflow cases keeps the divider defined;
  // for overflow it also yields exactly quotient=a, remainder=0.
  assign w_sdivisor = (w_b_zero || w_ovf) ? C_ONE : b;
  assign w_udivisor = w_b_zero ? C_ONE : b;

  assign w_sq = $signed(a) / $signed(w_sdivisor);
  assign w_sr = $signed(a) % $signed(w_sdivisor);
  assign w_uq = a / w_udivisor;
  assign w_ur = a % w_udivisor;

  assign div_zero = md_is_div(op) && w_b_zero;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT:  begin res_hi = w_sprod[2*WIDTH-1:WIDTH]; res_lo = w_sprod[WIDTH-1:0]; end
      MD_MULTU: begin res_hi = w_uprod[2*WIDTH-1:WIDTH]; res_lo = w_uprod[WIDTH-1:0]; end
      MD_DIV:   begin res_hi = w_sr; res_lo = w_sq; end
      MD_DIVU:  begin res_hi = w_ur; res_lo = w_uq; end
      default:  begin res_hi = '0; res_lo = '0; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Brief    : Multi-cycle MULT/DIV sequencer with architectural HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] C_MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] C_DIV_N  = 4'(DIV_CYCLES);

  md_state_t        r_state, w_state_next;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic             r_pend_ok, r_done;
  logic             w_accept, w_last;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;
  logic             w_div_zero;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .op       (md_op),
    .a        (a),
    .b        (b),
    .res_hi   (w_res_hi),
    .res_lo   (w_res_lo),
    .div_zero (w_div_zero)
  );

  assign w_accept = start && !cancel && (r_state == ST_IDLE);
  assign w_last   = (r_state == ST_RUN) && !cancel && (r_cnt == 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && md_is_arith(md_op)) w_state_next = ST_RUN;
      ST_RUN:  if (cancel || (r_cnt == 4'd1))      w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= 4'd0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_ok <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        if (md_is_arith(md_op)) begin
          r_cnt     <= md_is_div(md_op) ? C_DIV_N : C_MULT_N;
          r_pend_hi <= w_res_hi;
          r_pend_lo <= w_res_lo;
          r_pend_ok <= !w_div_zero;
        end
        if (md_op == MD_MTHI) r_hi <= a;
        if (md_op == MD_MTLO) r_lo <= a;
      end else if (r_state == ST_RUN) begin
        if (cancel) begin
          // Flush: drop the in-flight result without touching HI/LO.
          r_cnt     <= 4'd0;
          r_pend_hi <= '0;
          r_pend_lo <= '0;
          r_pend_ok <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
          if (w_last && r_pend_ok) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
          end
        end
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the Execute stage beside the ALU and supplies the HI/LO values that the Execute write-data mux selects for MFHI/MFLO.
- Models fixed MULT/DIV latency with a countdown counter and exports busy so hazard logic can stall later mult/div/MT/MF instructions.
- A cancel input supports flush of the in-flight operation.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  issue strobe for md_op in the current cycle.
- md_op  input  3  operation code; encodings in md_pkg.
- a  input  WIDTH  rs operand, post-forwarding.
- b  input  WIDTH  rt operand, post-forwarding.
- cancel  input  1  abort the in-flight op; HI/LO are left unchanged.
- busy  output  1  a mult/div is in progress.
- done  output  1  one-cycle pulse in the cycle after HI/LO commit.
- hi  output  WIDTH  current HI register.
- lo  output  WIDTH  current LO register.

Behaviour:
- Reset (asynchronous): hi=0, lo=0, busy=0, done=0, counter=0, pending results=0, state IDLE.
- States:
  - IDLE: accepts operations.
  - RUN: counter nonzero; busy=1.
- Issue rule: an op is accepted only when start=1, cancel=0 and state=IDLE. In RUN, start is ignored; hazard logic must stall using start|busy.
- Accepting MULT/MULTU/DIV/DIVU at edge k:
  - The full result is computed from a and b and latched into pend_hi/pend_lo.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES) and state goes to RUN.
  - busy is high in cycles k+1 .. k+N.
  - At edge k+N: hi<=pend_hi, lo<=pend_lo, state returns to IDLE, and done is high for one cycle.
  - A new op may be accepted in the cycle right after busy falls.
- MULT: signed 2*WIDTH-bit product. hi=upper WIDTH bits, lo=lower WIDTH bits. MULTU is the same with unsigned operands.
- DIV: signed division, quotient truncated toward zero. lo=quotient; hi=remainder, which carries the sign of the dividend.
  - Overflow case (a = most negative, b = -1): lo=a, hi=0.
- DIVU: unsigned division; lo=quotient, hi=remainder.
- Divide by zero (b=0, DIV or DIVU): the op is accepted and busy runs the full DIV_CYCLES, but hi/lo are unchanged at commit.
- MTHI/MTLO: in IDLE, the register takes a at the next edge. busy stays 0 and done stays 0.
- MFHI/MFLO need no op: hi/lo are readable combinationally every cycle. During RUN they show the old values.
- Code NONE, or undefined codes 7: no effect.
- cancel=1 in RUN: at the next edge the counter clears, state goes to IDLE, busy=0, the pending result is discarded and done is not pulsed.
- cancel=1 in IDLE: blocks issue in that cycle and has no other effect.
- cancel on the same edge as the final count: cancel wins and there is no commit.
- Counter width is 4 bits. It decrements once per cycle in RUN and never wraps.

Decomposition:
- md_pkg holds:
  - Opcode constants: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
  - The state encoding (IDLE/RUN) and the default latency constants.
- One sub-module, md_arith: combinational and parametrised on WIDTH. Takes op, a, b; produces res_hi, res_lo, div_zero. This isolates the signed/unsigned and overflow rules from the sequencer.

Test Plan:
- MULT a=0xFFFFFFFE(-2), b=3, then hold start=0 → busy high for exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7(0xFFFFFFF9), b=2 → busy for 10 cycles; then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU with b=0 while hi/lo preloaded via MTHI 0x11 and MTLO 0x22 → busy for 10 cycles, hi=0x11, lo=0x22 after.
- DIV starts, and cancel=1 arrives in its 4th busy cycle → busy drops the next cycle, done stays 0, hi/lo unchanged.
- With DIV in flight, issue MULT start=1 → ignored.
- Asserting reset mid-RUN → busy, hi and lo go to 0 immediately, with no clock edge.
